// File: rtl/ysyx_22051013_wbu_pipe.sv
// Writeback stage: forms the register-file write value (load extension, ALU, link PC),
// buffers it in a small FIFO and issues one registered write per popped entry.
module ysyx_22051013_wbu_pipe #(
    parameter int unsigned DW    = 64,
    parameter int unsigned RAW   = 5,
    parameter int unsigned DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                wb_ctl,
    input  logic [RAW-1:0]            rd,
    input  logic [DW-1:0]             alu_res,
    input  logic [DW-1:0]             ls_rd_data,
    input  logic [DW-1:0]             snpc,
    input  logic [1:0]                ld_size,
    input  logic                      ld_unsigned,
    input  logic [$clog2(DW/8)-1:0]   ld_offset,
    input  logic                      wb_stall,
    input  logic                      flush,
    output logic                      rf_wen,
    output logic [RAW-1:0]            rf_waddr,
    output logic [DW-1:0]             rf_wdata,
    output logic                      busy,
    output logic [31:0]               retire_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0]  mem_data_q [DEPTH];
    logic [RAW-1:0] mem_rd_q   [DEPTH];
    logic           mem_wf_q   [DEPTH];

    logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rf_wen_q;
    logic [RAW-1:0] rf_waddr_q;
    logic [DW-1:0]  rf_wdata_q;
    logic [31:0]    retire_q;

    logic           push, pop, wflag, sbit;
    logic [DW-1:0]  shifted, ld_mask, ld_val, wb_data;
    int unsigned    lw;

    // Load extension: bytes shifted past the top of the bus fill with zero.
    always_comb begin
        shifted = ls_rd_data >> {ld_offset, 3'b000};
        lw      = 32'd8 << ld_size;
        if (lw > DW) lw = DW;
        ld_mask = (lw >= DW) ? '1 : ((DW'(1) << lw) - DW'(1));
        case (ld_size)
            2'b00:   sbit = shifted[7];
            2'b01:   sbit = shifted[15];
            2'b10:   sbit = shifted[31];
            default: sbit = shifted[DW-1];
        endcase
        sbit   = sbit & ~ld_unsigned;
        ld_val = (shifted & ld_mask) | ({DW{sbit}} & ~ld_mask);
    end

    always_comb begin
        case (wb_ctl)
            2'b01:   wb_data = ld_val;
            2'b10:   wb_data = alu_res;
            2'b11:   wb_data = snpc;
            default: wb_data = '0;
        endcase
        wflag = (wb_ctl != 2'b00) && (rd != '0);
    end

    assign in_ready = (cnt_q != CW'(DEPTH));
    assign push     = in_valid && in_ready && !flush;
    assign pop      = (cnt_q != '0) && !wb_stall && !flush;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wptr_q] <= wb_data;
            mem_rd_q[wptr_q]   <= rd;
            mem_wf_q[wptr_q]   <= wflag;
        end
    end

    // Address/data only move on a real write so they hold across idle and x0/none retires.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            retire_q   <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            rf_wen_q <= pop && mem_wf_q[rptr_q];
            if (pop && mem_wf_q[rptr_q]) begin
                rf_waddr_q <= mem_rd_q[rptr_q];
                rf_wdata_q <= mem_data_q[rptr_q];
            end
            if (pop) retire_q <= retire_q + 32'd1;
        end
    end

    assign rf_wen     = rf_wen_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign retire_cnt = retire_q;
    assign busy       = (cnt_q != '0) || rf_wen_q;

endmodule

// File: tb/tb_ysyx_22051013_wbu_pipe.sv
// Directed bench for the writeback FIFO: table of single-entry vectors plus multi-cycle sequences.
module tb_ysyx_22051013_wbu_pipe;

    logic        clk, rst, in_valid, in_ready;
    logic [1:0]  wb_ctl, ld_size;
    logic [4:0]  rd, rf_waddr;
    logic [63:0] alu_res, ls_rd_data, snpc, rf_wdata;
    logic        ld_unsigned, wb_stall, flush, rf_wen, busy;
    logic [2:0]  ld_offset;
    logic [31:0] retire_cnt;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] exp_ret;

    ysyx_22051013_wbu_pipe #(.DW(64), .RAW(5), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .wb_ctl(wb_ctl), .rd(rd), .alu_res(alu_res), .ls_rd_data(ls_rd_data),
        .snpc(snpc), .ld_size(ld_size), .ld_unsigned(ld_unsigned), .ld_offset(ld_offset),
        .wb_stall(wb_stall), .flush(flush), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .busy(busy), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ctl;
        logic [4:0]  rd;
        logic [63:0] alu;
        logic [63:0] ls;
        logic [63:0] pc;
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  off;
        logic        exp_wen;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_entry(input logic [1:0] c, input logic [4:0] r, input logic [63:0] a);
        in_valid = 1'b1;
        wb_ctl   = c;
        rd       = r;
        alu_res  = a;
    endtask

    initial begin
        vecs[0]  = '{2'b01, 5'd5,  64'h0, 64'h0000_0000_8000_0000, 64'h0, 2'b00, 1'b0, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1]  = '{2'b01, 5'd6,  64'h0, 64'h0000_0000_8000_0000, 64'h0, 2'b00, 1'b1, 3'd3, 1'b1, 64'h0000_0000_0000_0080};
        vecs[2]  = '{2'b01, 5'd10, 64'h0, 64'h1122_3344_8899_AABB, 64'h0, 2'b01, 1'b0, 3'd2, 1'b1, 64'hFFFF_FFFF_FFFF_8899};
        vecs[3]  = '{2'b01, 5'd31, 64'h0, 64'h8765_4321_0000_0000, 64'h0, 2'b10, 1'b0, 3'd4, 1'b1, 64'hFFFF_FFFF_8765_4321};
        vecs[4]  = '{2'b01, 5'd30, 64'h0, 64'h8765_4321_0000_0000, 64'h0, 2'b10, 1'b1, 3'd4, 1'b1, 64'h0000_0000_8765_4321};
        vecs[5]  = '{2'b01, 5'd2,  64'h0, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 2'b11, 1'b0, 3'd0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[6]  = '{2'b01, 5'd3,  64'h0, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 2'b11, 1'b0, 3'd1, 1'b1, 64'h00DE_ADBE_EFCA_FEF0};
        vecs[7]  = '{2'b01, 5'd4,  64'h0, 64'hFF00_0000_0000_0000, 64'h0, 2'b01, 1'b0, 3'd7, 1'b1, 64'h0000_0000_0000_00FF};
        vecs[8]  = '{2'b10, 5'd1,  64'h1234_5678_9ABC_DEF0, 64'h5555, 64'h0, 2'b00, 1'b0, 3'd0, 1'b1, 64'h1234_5678_9ABC_DEF0};
        vecs[9]  = '{2'b11, 5'd1,  64'h7777, 64'h5555, 64'h8000_0004, 2'b00, 1'b0, 3'd0, 1'b1, 64'h0000_0000_8000_0004};
        vecs[10] = '{2'b10, 5'd0,  64'hAAAA, 64'h0, 64'h0, 2'b00, 1'b0, 3'd0, 1'b0, 64'h0};
        vecs[11] = '{2'b00, 5'd7,  64'hBBBB, 64'h0, 64'h0, 2'b00, 1'b0, 3'd0, 1'b0, 64'h0};

        rst = 1'b0; in_valid = 1'b0; wb_ctl = 2'b00; rd = '0; alu_res = '0; ls_rd_data = '0;
        snpc = '0; ld_size = 2'b00; ld_unsigned = 1'b0; ld_offset = '0; wb_stall = 1'b0; flush = 1'b0;
        tick; tick;
        chk("rst_wen", rf_wen, 1'b0);
        chk("rst_waddr", rf_waddr, 5'd0);
        chk("rst_wdata", rf_wdata, 64'h0);
        chk("rst_retire", retire_cnt, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        rst = 1'b1;
        tick;
        exp_ret = 32'd0;

        // Table vectors: one entry through an empty, unstalled buffer.
        for (int i = 0; i < 12; i++) begin
            in_valid    = 1'b1;
            wb_ctl      = vecs[i].ctl;
            rd          = vecs[i].rd;
            alu_res     = vecs[i].alu;
            ls_rd_data  = vecs[i].ls;
            snpc        = vecs[i].pc;
            ld_size     = vecs[i].size;
            ld_unsigned = vecs[i].uns;
            ld_offset   = vecs[i].off;
            tick;
            in_valid = 1'b0;
            chk($sformatf("vec%0d_wen_accept", i), rf_wen, 1'b0);
            chk($sformatf("vec%0d_busy", i), busy, 1'b1);
            tick;
            exp_ret = exp_ret + 32'd1;
            chk($sformatf("vec%0d_wen", i), rf_wen, vecs[i].exp_wen);
            if (vecs[i].exp_wen) begin
                chk($sformatf("vec%0d_waddr", i), rf_waddr, vecs[i].rd);
                chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].exp_data);
            end
            chk($sformatf("vec%0d_retire", i), retire_cnt, exp_ret);
            tick;
            chk($sformatf("vec%0d_wen_after", i), rf_wen, 1'b0);
        end

        // Back-to-back ALU entries from a clean reset.
        rst = 1'b0; tick; rst = 1'b1;
        set_entry(2'b10, 5'd1, 64'd1); tick;
        chk("b2b_ready1", in_ready, 1'b1);
        chk("b2b_wen0", rf_wen, 1'b0);
        set_entry(2'b10, 5'd2, 64'd2); tick;
        chk("b2b_ready2", in_ready, 1'b1);
        chk("b2b_wen1", rf_wen, 1'b1); chk("b2b_addr1", rf_waddr, 5'd1); chk("b2b_data1", rf_wdata, 64'd1);
        set_entry(2'b10, 5'd3, 64'd3); tick;
        chk("b2b_ready3", in_ready, 1'b1);
        chk("b2b_wen2", rf_wen, 1'b1); chk("b2b_addr2", rf_waddr, 5'd2); chk("b2b_data2", rf_wdata, 64'd2);
        in_valid = 1'b0; tick;
        chk("b2b_wen3", rf_wen, 1'b1); chk("b2b_addr3", rf_waddr, 5'd3); chk("b2b_data3", rf_wdata, 64'd3);
        tick;
        chk("b2b_idle_wen", rf_wen, 1'b0);
        chk("b2b_retire", retire_cnt, 32'd3);
        chk("b2b_busy", busy, 1'b0);

        // Fill under stall, then drain; the entry offered while full must be refused.
        wb_stall = 1'b1;
        set_entry(2'b10, 5'd11, 64'hA); tick;
        chk("full_ready_occ1", in_ready, 1'b1);
        set_entry(2'b10, 5'd12, 64'hB); tick;
        chk("full_ready_occ2", in_ready, 1'b0);
        chk("full_wen_stalled", rf_wen, 1'b0);
        set_entry(2'b10, 5'd13, 64'hC);
        wb_stall = 1'b0; tick;
        in_valid = 1'b0;
        chk("drain_wen1", rf_wen, 1'b1); chk("drain_addr1", rf_waddr, 5'd11); chk("drain_data1", rf_wdata, 64'hA);
        chk("drain_ready", in_ready, 1'b1);
        tick;
        chk("drain_wen2", rf_wen, 1'b1); chk("drain_addr2", rf_waddr, 5'd12); chk("drain_data2", rf_wdata, 64'hB);
        tick;
        chk("drain_no_extra", rf_wen, 1'b0);
        chk("drain_retire", retire_cnt, 32'd5);
        chk("drain_busy", busy, 1'b0);

        // Flush with a simultaneous offer: nothing retires, nothing is accepted.
        wb_stall = 1'b1;
        set_entry(2'b10, 5'd14, 64'h14); tick;
        set_entry(2'b10, 5'd15, 64'h15); tick;
        set_entry(2'b10, 5'd20, 64'h20);
        flush = 1'b1; tick;
        flush = 1'b0; in_valid = 1'b0; wb_stall = 1'b0;
        chk("flush_wen", rf_wen, 1'b0);
        chk("flush_busy", busy, 1'b0);
        chk("flush_ready", in_ready, 1'b1);
        chk("flush_retire", retire_cnt, 32'd5);
        tick;
        chk("flush_wen_next", rf_wen, 1'b0);
        chk("flush_retire_next", retire_cnt, 32'd5);

        // Reset while a write is on the port and another entry is buffered.
        set_entry(2'b10, 5'd8, 64'h88); tick;
        set_entry(2'b10, 5'd9, 64'h99); tick;
        in_valid = 1'b0;
        chk("rmid_wen_before", rf_wen, 1'b1);
        rst = 1'b0; tick;
        chk("rmid_wen", rf_wen, 1'b0);
        chk("rmid_retire", retire_cnt, 32'd0);
        chk("rmid_busy", busy, 1'b0);
        chk("rmid_waddr", rf_waddr, 5'd0);
        rst = 1'b1; tick;
        chk("rmid_ready", in_ready, 1'b1);
        chk("rmid_no_write", rf_wen, 1'b0);
        tick;
        chk("rmid_retire_after", retire_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
